// File: rtl/food_spawner_pkg.sv
// Shared snake-game constants, FSM encoding and LFSR tap mask.
package food_spawner_pkg;

    localparam int GRID_W   = 40;
    localparam int GRID_H   = 30;
    localparam int CELL_PX  = 16;
    localparam int SCREEN_W = 640;
    localparam int SCREEN_H = 480;

    // x^16 + x^15 + x^13 + x^4 + 1 -> feedback from bits 15, 14, 12, 3
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRAW,
        ST_QUERY,
        ST_WAIT,
        ST_SCAN,
        ST_EMIT
    } state_t;

endpackage

// File: rtl/lfsr16.sv
// Seeded free-running 16-bit Fibonacci LFSR, shifting every cycle out of reset.
module lfsr16
    import food_spawner_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [15:0] o_lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    assign lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign o_lfsr = lfsr_q;

endmodule

// File: rtl/food_spawner.sv
// Picks a free grid cell for the next food item: random draws first, linear scan as fallback.
module food_spawner #(
    parameter int          GRID_W    = food_spawner_pkg::GRID_W,
    parameter int          GRID_H    = food_spawner_pkg::GRID_H,
    parameter int          CELL_PX   = food_spawner_pkg::CELL_PX,
    parameter int          MAX_TRIES = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_ate_req,
    output logic [5:0] o_occ_x,
    output logic [4:0] o_occ_y,
    output logic       o_occ_req,
    input  logic       i_occ_hit,
    output logic [9:0] o_food_x,
    output logic [9:0] o_food_y,
    output logic       o_food_valid,
    output logic       o_busy,
    output logic       o_grid_full
);

    import food_spawner_pkg::*;

    localparam int          SH        = $clog2(CELL_PX);
    localparam logic [5:0]  GW        = 6'(GRID_W);
    localparam logic [4:0]  GH        = 5'(GRID_H);
    localparam logic [3:0]  TRY_LIM   = 4'(MAX_TRIES);
    localparam logic [10:0] SCAN_LAST = 11'(GRID_W * GRID_H - 1);

    state_t      state_q, state_d;
    logic [5:0]  cand_x_q, cand_x_d;
    logic [4:0]  cand_y_q, cand_y_d;
    logic [3:0]  tries_q, tries_d;
    logic        scan_q, scan_d;
    logic [10:0] scnt_q, scnt_d;
    logic [9:0]  food_x_q, food_x_d;
    logic [9:0]  food_y_q, food_y_d;
    logic        full_q, full_d;

    logic [15:0] lfsr;
    logic [5:0]  draw_x;
    logic [4:0]  draw_y;
    logic [3:0]  tries_inc;
    logic        lfsr_unused;

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .o_lfsr (lfsr)
    );

    assign draw_x      = lfsr[5:0];
    assign draw_y      = lfsr[10:6];
    assign lfsr_unused = ^lfsr[15:11];
    assign tries_inc   = tries_q + 4'd1;

    always_comb begin
        state_d  = state_q;
        cand_x_d = cand_x_q;
        cand_y_d = cand_y_q;
        tries_d  = tries_q;
        scan_d   = scan_q;
        scnt_d   = scnt_q;
        food_x_d = food_x_q;
        food_y_d = food_y_q;
        full_d   = full_q;
        unique case (state_q)
            ST_IDLE: begin
                if (i_ate_req && !full_q) begin
                    tries_d = '0;
                    scan_d  = 1'b0;
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                // Only in-range draws are latched, so a scan always starts on a legal cell.
                if (draw_x >= GW || draw_y >= GH) begin
                    tries_d = tries_inc;
                    if (tries_inc == TRY_LIM) state_d = ST_SCAN;
                end else begin
                    cand_x_d = draw_x;
                    cand_y_d = draw_y;
                    state_d  = ST_QUERY;
                end
            end
            ST_QUERY: state_d = ST_WAIT;
            ST_WAIT: begin
                if (!i_occ_hit) begin
                    food_x_d = 10'(cand_x_q) << SH;
                    food_y_d = 10'(cand_y_q) << SH;
                    state_d  = ST_EMIT;
                end else if (scan_q) begin
                    state_d = ST_SCAN;
                end else begin
                    tries_d = tries_inc;
                    state_d = (tries_inc == TRY_LIM) ? ST_SCAN : ST_DRAW;
                end
            end
            ST_SCAN: begin
                // First visit tests the current cell; later visits step row-major with wrap.
                if (!scan_q) begin
                    scan_d  = 1'b1;
                    scnt_d  = SCAN_LAST;
                    state_d = ST_QUERY;
                end else if (scnt_q == '0) begin
                    full_d  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    if (cand_x_q == GW - 6'd1) begin
                        cand_x_d = '0;
                        cand_y_d = (cand_y_q == GH - 5'd1) ? 5'd0 : cand_y_q + 5'd1;
                    end else begin
                        cand_x_d = cand_x_q + 6'd1;
                    end
                    scnt_d  = scnt_q - 11'd1;
                    state_d = ST_QUERY;
                end
            end
            ST_EMIT: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            cand_x_q <= '0;
            cand_y_q <= '0;
            tries_q  <= '0;
            scan_q   <= 1'b0;
            scnt_q   <= '0;
            food_x_q <= '0;
            food_y_q <= '0;
            full_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cand_x_q <= cand_x_d;
            cand_y_q <= cand_y_d;
            tries_q  <= tries_d;
            scan_q   <= scan_d;
            scnt_q   <= scnt_d;
            food_x_q <= food_x_d;
            food_y_q <= food_y_d;
            full_q   <= full_d;
        end
    end

    assign o_occ_x      = cand_x_q;
    assign o_occ_y      = cand_y_q;
    assign o_occ_req    = (state_q == ST_QUERY);
    assign o_food_x     = food_x_q;
    assign o_food_y     = food_y_q;
    assign o_food_valid = (state_q == ST_EMIT);
    assign o_busy       = (state_q != ST_IDLE);
    assign o_grid_full  = full_q;

endmodule
